// File: rtl/first_counter_pkg.sv
// Shared constants for the first_counter event/cycle counter.
// Holds the default counter width and a helper that gives the largest
// value a counter of a given width can hold before it wraps.
package first_counter_pkg;

    // Default counter width; at 4 bits the counter wraps after 15.
    localparam int DEFAULT_WIDTH = 4;

    // Largest count representable in 'width' bits (2^width - 1).
    function automatic int unsigned max_count(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage : first_counter_pkg

// File: rtl/first_counter.sv
// first_counter: free-running up-counter with count enable and a sticky
// overflow flag that records that the count has wrapped at least once.
// Optional build macro FIRST_COUNTER_WRAP_PULSE_EN adds a registered
// wrap_pulse output that is high for the single cycle after each wrap.
// All outputs come straight from registers; reset is async, active-high.
module first_counter
    import first_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] counter_out,
    output logic             overflow_out
`ifdef FIRST_COUNTER_WRAP_PULSE_EN
    ,
    output logic             wrap_pulse
`endif
);

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(max_count(WIDTH));

    logic wrap;

    // A wrap happens on an enabled edge while the count sits at its maximum.
    assign wrap = enable && (counter_out == MAX_COUNT);

    // Count register: advances modulo 2^WIDTH on enabled edges, holds otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter_out <= '0;
        end else if (enable) begin
            counter_out <= counter_out + 1'b1;
        end
    end

    // Sticky flag: set on the first wrap and held until the next reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_out <= 1'b0;
        end else if (wrap) begin
            overflow_out <= 1'b1;
        end
    end

`ifdef FIRST_COUNTER_WRAP_PULSE_EN
    // One-cycle marker for every wrap edge, including those after the first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= wrap;
        end
    end
`endif

endmodule : first_counter

// File: tb/tb_first_counter.sv
// Directed self-checking bench for first_counter at the default width.
// Covers reset behaviour, counting, wrap, sticky overflow, hold at max and
// asynchronous reset in the middle of a run.
module tb_first_counter;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] counter_out;
    logic       overflow_out;
`ifdef FIRST_COUNTER_WRAP_PULSE_EN
    logic       wrap_pulse;
`endif

    int checks;
    int errors;

    first_counter #(.WIDTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .counter_out  (counter_out),
        .overflow_out (overflow_out)
`ifdef FIRST_COUNTER_WRAP_PULSE_EN
        ,
        .wrap_pulse   (wrap_pulse)
`endif
    );

    // 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive enable on the falling edge, then sample 1 unit after the rising edge.
    task automatic applyStimulus(input logic en);
        @(negedge clk);
        enable = en;
        @(posedge clk);
        #1;
    endtask

    // Compare every output against the expected values.
    task automatic checkOutput(input string tag, input logic [3:0] exp_count,
                               input logic exp_ov, input logic exp_pulse);
        checks++;
        assert (counter_out === exp_count) else begin
            errors++;
            $error("[TB] FAIL %s counter_out got %0d expected %0d", tag, counter_out, exp_count);
        end
        checks++;
        assert (overflow_out === exp_ov) else begin
            errors++;
            $error("[TB] FAIL %s overflow_out got %b expected %b", tag, overflow_out, exp_ov);
        end
`ifdef FIRST_COUNTER_WRAP_PULSE_EN
        checks++;
        assert (wrap_pulse === exp_pulse) else begin
            errors++;
            $error("[TB] FAIL %s wrap_pulse got %b expected %b", tag, wrap_pulse, exp_pulse);
        end
`else
        if (exp_pulse === 1'bx) begin
            $display("[TB] note: unexpected pulse expectation in %s", tag);
        end
`endif
    endtask

    // Pulse reset for one cycle with enable low, release on a falling edge.
    task automatic doReset();
        @(negedge clk);
        enable = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        enable = 1'b0;

        // Power-up: async reset takes effect without a clock edge.
        #3;
        reset = 1'b1;
        #1;
        checkOutput("pwr_async", 4'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("pwr_held", 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("pwr_release", 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0);
            checkOutput("pwr_idle", 4'd0, 1'b0, 1'b0);
        end

        // Basic count 1..10, no overflow.
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b1);
            checkOutput("basic", 4'(i), 1'b0, 1'b0);
        end

        // Wrap from 0: 16th edge returns to 0 and raises overflow.
        doReset();
        #1;
        checkOutput("wrap_rst", 4'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1);
            checkOutput("wrap", 4'(i % 16), (i == 16), (i == 16));
        end
        applyStimulus(1'b0);
        checkOutput("wrap_after", 4'd0, 1'b1, 1'b0);

        // Long run of 100 edges: overflow sticky from edge 16 onward.
        doReset();
        for (int i = 1; i <= 100; i++) begin
            applyStimulus(1'b1);
            checkOutput("long", 4'(i % 16), (i >= 16), ((i % 16) == 0));
        end
        checkOutput("long_final", 4'd4, 1'b1, 1'b0);

        // Hold at max: disabled edges never set the flag.
        doReset();
        for (int i = 1; i <= 15; i++) begin
            applyStimulus(1'b1);
        end
        checkOutput("max_reach", 4'd15, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0);
            checkOutput("max_hold", 4'd15, 1'b0, 1'b0);
        end
        applyStimulus(1'b1);
        checkOutput("max_wrap", 4'd0, 1'b1, 1'b1);
        applyStimulus(1'b0);
        checkOutput("max_post", 4'd0, 1'b1, 1'b0);

        // Async reset mid-run with count 7 and overflow set.
        doReset();
        for (int i = 1; i <= 23; i++) begin
            applyStimulus(1'b1);
        end
        checkOutput("mid_pre", 4'd7, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid_async", 4'd0, 1'b0, 1'b0);
        // Reset wins over an enabled clock edge.
        enable = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid_rst_wins", 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mid_resume", 4'd1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_first_counter
